// File: rtl/nios_security_pio_pkg.sv
// Shared constants and bus request type for the security input PIO.
package nios_security_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } avl_req_t;

endpackage

// File: rtl/nios_security_pio_filter.sv
// One input bit: synchroniser chain followed by an optional stability filter.
module nios_security_pio_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  if (FILTER_CYCLES == 0) begin : g_nofilt
    assign dout = sync_q[SYNC_STAGES-1];
  end else begin : g_filt
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          q;

    // For a single bit, "differs from data_in" for consecutive clocks is the
    // same as "stable and different", so any return to q restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == q) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        q   <= sync_q[SYNC_STAGES-1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign dout = q;
  end

endmodule

// File: rtl/nios_security_pio_capture.sv
// Avalon-MM input PIO: per-bit sync/filter, armed edge capture, mask, read mux and irq.
module nios_security_pio_capture
  import nios_security_pio_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int EDGE_TYPE     = 0,
  parameter int IRQ_MODE      = 0,
  parameter int BIT_CLEAR     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  localparam int ARM_INIT = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int AW       = $clog2(ARM_INIT + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nios_security_pio_capture: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("nios_security_pio_capture: SYNC_STAGES must be 2..4");
  end

  avl_req_t         req;
  logic [WIDTH-1:0] data_in, data_d, irq_mask, edge_capture;
  logic [WIDTH-1:0] edge_det, clr_bits, rd_mux;
  logic [AW-1:0]    arm_cnt;
  logic             wr_mask, wr_capt;

  assign req = '{sel: chipselect, wr: ~write_n, addr: address, wdata: writedata};

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = &{1'b0, req.wdata[31:WIDTH]};
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios_security_pio_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[g]),
      .dout (data_in[g])
    );
  end

  assign wr_mask = req.sel & req.wr & (req.addr == ADDR_MASK);
  assign wr_capt = req.sel & req.wr & (req.addr == ADDR_CAPT);

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE)      edge_det = data_in & ~data_d;
    else if (EDGE_TYPE == EDGE_FALL) edge_det = ~data_in & data_d;
    else                             edge_det = data_in ^ data_d;
    clr_bits = '0;
    if (wr_capt) clr_bits = (BIT_CLEAR != 0) ? req.wdata[WIDTH-1:0] : '1;
  end

  always_comb begin
    case (address)
      ADDR_DATA: rd_mux = data_in;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_CAPT: rd_mux = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // The arm window covers the input path latency so levels present at reset
  // never look like edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt      <= AW'(ARM_INIT);
      data_d       <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      if (arm_cnt != '0) arm_cnt <= arm_cnt - AW'(1);
      data_d       <= data_in;
      if (wr_mask) irq_mask <= req.wdata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr_bits) | (edge_det & {WIDTH{arm_cnt == '0}});
      readdata     <= 32'(rd_mux);
    end
  end

  assign irq = ~reset & ((IRQ_MODE == IRQ_EDGE) ? |(edge_capture & irq_mask)
                                                : |(data_in & irq_mask));

endmodule
